// File: rtl/gray_rx_checker_pkg.sv
// gray_pkg: shared widths, tracker state encoding and Gray/binary helpers
package gray_pkg;
    localparam int CBITS_DEF = 9;
    localparam int ECW_DEF = 4;
    typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;
    function automatic logic [CBITS_DEF-1:0] gray2bin(input logic [CBITS_DEF-1:0] g);
        logic [CBITS_DEF-1:0] b;
        for (int i = 0; i < CBITS_DEF; i++) b[i] = ^(g >> i);
        return b;
    endfunction
    function automatic logic is_legal_step(input logic [CBITS_DEF-1:0] prev, input logic [CBITS_DEF-1:0] next);
        return (next == prev) || (next == prev + 1'b1);
    endfunction
endpackage

// File: rtl/gray_rx_checker_if.sv
// gray_rx_checker_if: sample strobe, Gray input and decoded/status outputs of the checker
interface gray_rx_checker_if import gray_pkg::*; #(
    parameter int CBITS = CBITS_DEF,
    parameter int ECW = ECW_DEF
);
    logic en;
    logic [CBITS-1:0] gray_in;
    logic clr_err;
    logic [CBITS-1:0] bin_out;
    logic bin_valid;
    logic wrap;
    logic step_err;
    logic err_sticky;
    logic [ECW-1:0] err_cnt;
    logic primed;
    modport master (
        output en, gray_in, clr_err,
        input bin_out, bin_valid, wrap, step_err, err_sticky, err_cnt, primed
    );
    modport slave (
        input en, gray_in, clr_err,
        output bin_out, bin_valid, wrap, step_err, err_sticky, err_cnt, primed
    );
endinterface

// File: rtl/gray_rx_checker_g2b.sv
// gray2bin_comb: combinational Gray-to-binary decoder; each bit is the XOR of all Gray bits at or above it
module gray2bin_comb #(
    parameter int CBITS = 9
) (
    input  logic [CBITS-1:0] i_gray,
    output logic [CBITS-1:0] o_bin
);
    for (genvar i = 0; i < CBITS; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[CBITS-1:i];
    end
endmodule

// File: rtl/gray_rx_checker.sv
// gray_rx_checker: two-stage Gray sampler/decoder that flags any step other than hold or +1,
// publishes the binary count, a max->0 wrap pulse and sticky/saturating error status.
module gray_rx_checker import gray_pkg::*; #(
    parameter int CBITS = CBITS_DEF,
    parameter int ECW = ECW_DEF
) (
    input logic clk,
    input logic rst_n,
    gray_rx_checker_if.slave bus
);
    state_t r_state;
    state_t w_state_nxt;
    logic [CBITS-1:0] r_g_q;
    logic [CBITS-1:0] r_prev_bin;
    logic [CBITS-1:0] w_bin;
    logic r_s1_vld;
    logic r_bin_valid;
    logic r_wrap;
    logic r_step_err;
    logic r_err_sticky;
    logic [ECW-1:0] r_err_cnt;
    logic [ECW-1:0] w_err_cnt_nxt;
    logic w_chk;
    logic w_err;
    logic w_wrap;
    logic w_primed;

    gray2bin_comb #(.CBITS(CBITS)) u_g2b (.i_gray(r_g_q), .o_bin(w_bin));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else r_state <= w_state_nxt;
    end

    always_comb w_state_nxt = r_s1_vld ? TRACK : r_state;

    always_comb w_primed = (r_state == TRACK);

    // The first sample after reset only anchors prev_bin; it is never checked
    always_comb begin
        w_chk = r_s1_vld && (r_state == TRACK);
        w_err = w_chk && !is_legal_step(r_prev_bin, w_bin);
        w_wrap = w_chk && (r_prev_bin == '1) && (w_bin == '0);
        w_err_cnt_nxt = w_err ? (bus.clr_err ? ECW'(1) : (r_err_cnt == '1 ? r_err_cnt : r_err_cnt + 1'b1))
                              : (bus.clr_err ? '0 : r_err_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g_q <= '0;
            r_s1_vld <= 1'b0;
            r_prev_bin <= '0;
            r_bin_valid <= 1'b0;
            r_wrap <= 1'b0;
            r_step_err <= 1'b0;
            r_err_cnt <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_s1_vld <= bus.en;
            if (bus.en) r_g_q <= bus.gray_in;
            if (r_s1_vld) r_prev_bin <= w_bin;
            r_bin_valid <= r_s1_vld;
            r_wrap <= w_wrap;
            r_step_err <= w_err;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_sticky <= w_err | (r_err_sticky & ~bus.clr_err);
        end
    end

    // prev_bin doubles as the published count: both hold the last accepted sample
    assign bus.bin_out = r_prev_bin;
    assign bus.bin_valid = r_bin_valid;
    assign bus.wrap = r_wrap;
    assign bus.step_err = r_step_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt = r_err_cnt;
    assign bus.primed = w_primed;
endmodule

// File: tb/tb_gray_rx_checker.sv
// tb_gray_rx_checker: directed stimulus with a queue scoreboard popped by a bin_valid monitor
module tb_gray_rx_checker;
    import gray_pkg::*;
    localparam int CB = CBITS_DEF;

    typedef struct {int b; int w; int e;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_wrap = 0;

    always #5 clk = ~clk;

    gray_rx_checker_if #(.CBITS(CB), .ECW(ECW_DEF)) bus ();
    gray_rx_checker #(.CBITS(CB), .ECW(ECW_DEF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic send(input int g, input int b, input int w, input int e);
        @(negedge clk);
        bus.en = 1'b1;
        bus.gray_in = g[CB-1:0];
        q.push_back('{b, w, e});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.en = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic clr();
        @(negedge clk);
        bus.en = 1'b0;
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bin_valid) begin
                exp_t e;
                if (q.size() == 0) chk("unexpected_bin_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("bin_out", bus.bin_out, e.b);
                    chk("wrap", bus.wrap, e.w);
                    chk("step_err", bus.step_err, e.e);
                end
                if (bus.wrap) n_wrap++;
            end else if (bus.wrap || bus.step_err) chk("pulse_without_valid", 1, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b0;
        bus.gray_in = '0;
        bus.clr_err = 1'b0;
        #1;
        chk("rst_bin_out", bus.bin_out, 0);
        chk("rst_bin_valid", bus.bin_valid, 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_step_err", bus.step_err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_err_sticky", bus.err_sticky, 0);
        chk("rst_primed", bus.primed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // full sweep 0..511,0,1: single wrap on the second 0
        for (int n = 0; n < 514; n++) begin
            int m;
            m = n % 512;
            send(gray(m), m, (n == 512) ? 1 : 0, 0);
        end
        drain();
        chk("sweep_wrap_count", n_wrap, 1);
        chk("sweep_err_cnt", bus.err_cnt, 0);
        chk("sweep_err_sticky", bus.err_sticky, 0);
        chk("sweep_primed", bus.primed, 1);
        // sparse en: 10, seven idle cycles, 11
        for (int n = 2; n <= 10; n++) send(gray(n), n, 0, 0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("gap_bin_valid", bus.bin_valid, 0);
        end
        send('h00E, 11, 0, 0);
        drain();
        chk("sparse_err_cnt", bus.err_cnt, 0);
        // fresh history, then hold at bin 4
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_primed", bus.primed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send('h006, 4, 0, 0);
        send('h006, 4, 0, 0);
        drain();
        chk("hold_err_cnt", bus.err_cnt, 0);
        chk("hold_primed", bus.primed, 1);
        // 4 -> 3 is illegal; clear, then 3 -> 5 illegal, 5 -> 6 legal
        send('h002, 3, 0, 1);
        drain();
        chk("down_err_cnt", bus.err_cnt, 1);
        clr();
        chk("clr_err_cnt", bus.err_cnt, 0);
        chk("clr_err_sticky", bus.err_sticky, 0);
        send('h007, 5, 0, 1);
        send('h005, 6, 0, 0);
        drain();
        chk("jump_err_cnt", bus.err_cnt, 1);
        chk("jump_err_sticky", bus.err_sticky, 1);
        // 21 illegal jumps saturate the counter at 15
        send('h056, 100, 0, 1);
        for (int i = 0; i < 19; i++) begin
            if (i % 2 == 0) send(0, 0, 0, 1);
            else send('h056, 100, 0, 1);
        end
        drain();
        chk("sat_err_cnt", bus.err_cnt, 15);
        chk("sat_err_sticky", bus.err_sticky, 1);
        clr();
        chk("clr2_err_cnt", bus.err_cnt, 0);
        chk("clr2_err_sticky", bus.err_sticky, 0);
        // clr_err lands on the same edge as a new error: error wins
        send('h056, 100, 0, 1);
        @(negedge clk);
        bus.en = 1'b0;
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("clr_vs_err_cnt", bus.err_cnt, 1);
        chk("clr_vs_err_sticky", bus.err_sticky, 1);
        drain();
        // async reset while parked at bin 200
        send('h0A4, 199, 0, 1);
        send('h0AC, 200, 0, 0);
        drain();
        chk("pre_rst_bin_out", bus.bin_out, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bin_out", bus.bin_out, 0);
        chk("async_rst_err_cnt", bus.err_cnt, 0);
        chk("async_rst_err_sticky", bus.err_sticky, 0);
        chk("async_rst_primed", bus.primed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send('h02B, 50, 0, 0);
        drain();
        chk("post_rst_primed", bus.primed, 1);
        chk("post_rst_err_cnt", bus.err_cnt, 0);
        chk("post_rst_wrap_count", n_wrap, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
